// File: rtl/snes_audio_resampler.sv
// Stereo 32 kHz -> 48 kHz linear-interpolating resampler for the SNES DSP stream.
// A 4-entry input FIFO absorbs DSP jitter; one shared multiplier serves both channels.
module snes_audio_resampler #(
    parameter int unsigned CLK_HZ   = 21477000,
    parameter int unsigned IN_RATE  = 32000,
    parameter int unsigned OUT_RATE = 48000,
    parameter int unsigned STEP     =
        32'((64'(IN_RATE) << 16) / 64'(OUT_RATE))
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] in_l,
    input  logic signed [15:0] in_r,
    input  logic               in_valid,
    output logic               in_en,
    output logic signed [15:0] out_l,
    output logic signed [15:0] out_r,
    output logic               out_valid,
    output logic               underrun,
    output logic               overflow
);

    localparam logic [27:0] ACC_INC = 28'(OUT_RATE);
    localparam logic [27:0] ACC_LIM = 28'(CLK_HZ);
    localparam logic [16:0] STEP_W  = 17'(STEP);

    typedef enum logic [2:0] {
        IDLE,
        ADV,
        MUL_L,
        MUL_R,
        EMIT
    } state_t;

    state_t state_q, state_d;

    logic [26:0] acc_q, acc_d;
    logic [27:0] acc_sum;
    logic        tick;

    logic [15:0] phase_q, phase_d;
    logic [16:0] ph_sum;
    logic        carry;

    logic [31:0] s0_q, s0_d;
    logic [31:0] s1_q, s1_d;

    logic [31:0] mem_q [4];
    logic [31:0] mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        empty, full, push, pop;

    logic        in_en_q, in_en_d;
    logic signed [15:0] res_l_q, res_l_d;
    logic signed [15:0] out_l_q, out_l_d;
    logic signed [15:0] out_r_q, out_r_d;
    logic        out_valid_q, out_valid_d;
    logic        underrun_q, underrun_d;
    logic        overflow_q, overflow_d;

    logic signed [15:0] m_s0, m_s1, m_res;
    logic signed [16:0] m_diff, m_ph;
    logic signed [33:0] m_prod;
    logic        unused_bits;

    // Fractional tick divider: average rate OUT_RATE from CLK_HZ.
    always_comb begin
        acc_sum = {1'b0, acc_q} + ACC_INC;
        tick    = (acc_sum >= ACC_LIM);
        if (tick) begin
            acc_d = 27'(acc_sum - ACC_LIM);
        end else begin
            acc_d = acc_sum[26:0];
        end
    end

    always_comb begin
        ph_sum = {1'b0, phase_q} + STEP_W;
        carry  = ph_sum[16];
        empty  = (count_q == 3'd0);
        full   = (count_q == 3'd4);
        pop    = (state_q == ADV) && carry && !empty;
        push   = in_valid && (!full || pop);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_l, in_r};
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d    = count_q + {2'b0, push} - {2'b0, pop};
        in_en_d    = (count_d < 3'd3);
        overflow_d = overflow_q | (in_valid & full & ~pop);
    end

    // Shared multiplier: left channel in MUL_L, right channel otherwise.
    always_comb begin
        if (state_q == MUL_L) begin
            m_s0 = s0_q[31:16];
            m_s1 = s1_q[31:16];
        end else begin
            m_s0 = s0_q[15:0];
            m_s1 = s1_q[15:0];
        end
        m_diff      = {m_s1[15], m_s1} - {m_s0[15], m_s0};
        m_ph        = {1'b0, phase_q};
        m_prod      = 34'(m_diff) * 34'(m_ph);
        m_res       = m_s0 + m_prod[31:16];
        unused_bits = ^{m_prod[33:32], m_prod[15:0]};
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        res_l_d     = res_l_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        out_valid_d = 1'b0;
        underrun_d  = underrun_q;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = ADV;
                end
            end
            ADV: begin
                phase_d = ph_sum[15:0];
                if (carry) begin
                    s0_d = s1_q;
                    if (!empty) begin
                        s1_d = mem_q[rd_ptr_q];
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
                state_d = MUL_L;
            end
            MUL_L: begin
                res_l_d = m_res;
                state_d = MUL_R;
            end
            MUL_R: begin
                out_l_d     = res_l_q;
                out_r_d     = m_res;
                out_valid_d = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            phase_q     <= '0;
            s0_q        <= '0;
            s1_q        <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_en_q     <= 1'b1;
            res_l_q     <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_en_q     <= in_en_d;
            res_l_q     <= res_l_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_en     = in_en_q;
    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign out_valid = out_valid_q;
    assign underrun  = underrun_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_snes_audio_resampler.sv
// Bench for snes_audio_resampler: behavioural scoreboard plus hand-computed
// directed checks, scaled clock (480 Hz clk, 48 Hz out, 32 Hz in).
module tb_snes_audio_resampler;

    localparam int CLK_HZ   = 480;
    localparam int IN_RATE  = 32;
    localparam int OUT_RATE = 48;
    localparam int STEP     = 43690;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [15:0] in_l = '0;
    logic signed [15:0] in_r = '0;
    logic               in_valid = 1'b0;
    logic               in_en;
    logic signed [15:0] out_l;
    logic signed [15:0] out_r;
    logic               out_valid;
    logic               underrun;
    logic               overflow;

    always #5 clk = ~clk;

    snes_audio_resampler #(
        .CLK_HZ  (CLK_HZ),
        .IN_RATE (IN_RATE),
        .OUT_RATE(OUT_RATE)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .in_l     (in_l),
        .in_r     (in_r),
        .in_valid (in_valid),
        .in_en    (in_en),
        .out_l    (out_l),
        .out_r    (out_r),
        .out_valid(out_valid),
        .underrun (underrun),
        .overflow (overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input longint act,
                             input longint lo, input longint hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d",
                     name, act, lo, hi);
        end
    endtask

    typedef struct {
        int                 cyc;
        logic signed [15:0] l;
        logic signed [15:0] r;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mf[$];
    int          cyc = 0;
    int          macc = 0;
    int          mst = 0;
    int          mph = 0;
    int          ms0l = 0, ms0r = 0, ms1l = 0, ms1r = 0;
    bit          munder = 0;
    bit          mover = 0;

    function automatic logic signed [15:0] interp(input int a, input int b,
                                                  input int ph);
        longint p;
        p = longint'(b - a) * longint'(ph);
        return 16'(longint'(a) + (p >>> 16));
    endfunction

    // Reference model: pushes the expected response when an output is launched.
    always @(posedge clk) begin
        int          sz;
        int          sum;
        bit          popped;
        bit          tk;
        logic [31:0] w;
        exp_t        e;
        if (reset) begin
            cyc = 0; macc = 0; mst = 0; mph = 0;
            ms0l = 0; ms0r = 0; ms1l = 0; ms1r = 0;
            munder = 0; mover = 0;
            mf.delete();
            exp_q.delete();
        end else begin
            cyc++;
            sz = mf.size();
            popped = 0;
            tk = (macc + OUT_RATE >= CLK_HZ);
            macc = tk ? macc + OUT_RATE - CLK_HZ : macc + OUT_RATE;
            case (mst)
                0: if (tk) mst = 1;
                1: begin
                    sum = mph + STEP;
                    mph = sum % 65536;
                    if (sum >= 65536) begin
                        ms0l = ms1l;
                        ms0r = ms1r;
                        if (sz > 0) begin
                            w = mf.pop_front();
                            ms1l = int'($signed(w[31:16]));
                            ms1r = int'($signed(w[15:0]));
                            popped = 1;
                        end else begin
                            munder = 1;
                        end
                    end
                    e.cyc = cyc + 2;
                    e.l = interp(ms0l, ms1l, mph);
                    e.r = interp(ms0r, ms1r, mph);
                    exp_q.push_back(e);
                    mst = 2;
                end
                2: mst = 3;
                3: mst = 4;
                default: mst = 0;
            endcase
            if (in_valid) begin
                if (sz < 4 || popped) mf.push_back({in_l, in_r});
                else mover = 1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("sb_out_l", out_l, e.l);
                chk("sb_out_r", out_r, e.r);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("missing_strobe", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        chk("sb_underrun", underrun, munder);
        chk("sb_overflow", overflow, mover);
        chk("sb_in_en", in_en, mf.size() < 3);
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push_one(input logic signed [15:0] l,
                            input logic signed [15:0] r);
        in_l = l;
        in_r = r;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_strobe();
        bit ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("strobe_timeout", 0, 1);
    endtask

    int     en_exp[5] = '{1, 1, 0, 0, 0};
    int     ov_exp[5] = '{0, 0, 0, 0, 1};
    longint last_l;
    longint prev_l;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values and tick spacing (tick after 10 clk, 4 clk pipeline)
        do_reset();
        chk("rst_out_l", out_l, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_en", in_en, 1);
        chk("rst_underrun", underrun, 0);
        chk("rst_overflow", overflow, 0);
        wait_strobe();
        chk("t1_first_cyc", cyc, 13);
        chk("t1_out_l", out_l, 0);
        wait_strobe();
        chk("t1_period", cyc, 23);

        // Constant input at the nominal input rate
        do_reset();
        fork
            for (int j = 0; j < 12; j++) begin
                push_one(16'sh1000, 16'shF000);
                repeat (14) @(negedge clk);
            end
            for (int k = 1; k <= 14; k++) begin
                wait_strobe();
                if (k >= 4) begin
                    chk("t2_out_l", out_l, 16'sh1000);
                    chk("t2_out_r", out_r, 16'shF000);
                end
            end
        join
        chk("t2_underrun", underrun, 0);

        // Ramp input: 3000 per input sample -> 2000 per output sample
        do_reset();
        last_l = 0;
        prev_l = 0;
        fork
            for (int j = 0; j <= 10; j++) begin
                last_l = 3000 * j;
                push_one(16'(3000 * j), 16'(-3000 * j));
                repeat (14) @(negedge clk);
            end
            for (int k = 1; k <= 12; k++) begin
                wait_strobe();
                if (k >= 5) begin
                    chk_range("t3_step", out_l - prev_l, 1999, 2001);
                    chk_range("t3_le_latest", out_l, -32768, last_l);
                    chk_range("t3_mirror", out_l + out_r, -1, 0);
                end
                prev_l = out_l;
            end
        join

        // Burst of five pushes before any pop: last one overflows
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push_one(16'(256 * (k + 1)), 16'(-256 * (k + 1)));
            chk("t4_in_en", in_en, en_exp[k]);
            chk("t4_overflow", overflow, ov_exp[k]);
        end
        for (int k = 1; k <= 8; k++) begin
            wait_strobe();
            if (k == 4) chk("t4_out4_l", out_l, 426);
            if (k == 5) chk("t4_out5_l", out_l, 597);
            if (k == 7) begin
                chk("t4_out7_l", out_l, 938);
                chk("t4_underrun7", underrun, 0);
            end
            if (k == 8) begin
                chk("t4_out8_l", out_l, 1024);
                chk("t4_out8_r", out_r, -1024);
                chk("t4_underrun8", underrun, 1);
            end
        end
        chk("t4_overflow_sticky", overflow, 1);

        // Input stops: underrun, output holds the last sample
        do_reset();
        fork
            for (int j = 0; j < 3; j++) begin
                push_one(16'sh2000, 16'shE000);
                repeat (14) @(negedge clk);
            end
            for (int k = 1; k <= 8; k++) begin
                wait_strobe();
                if (k == 6) chk("t5_underrun6", underrun, 0);
                if (k == 7) begin
                    chk("t5_underrun7", underrun, 1);
                    chk("t5_out7_l", out_l, 16'sh2000);
                end
                if (k == 8) begin
                    chk("t5_out8_l", out_l, 16'sh2000);
                    chk("t5_out8_r", out_r, 16'shE000);
                end
            end
        join

        // Reset while the third output sits in MUL_R
        do_reset();
        push_one(16'sh4000, 16'sh4000);
        push_one(16'sh4000, 16'sh4000);
        wait_strobe();
        wait_strobe();
        chk("t6_pre_l", out_l, 5461);
        while (cyc < 32) @(negedge clk);
        reset = 1'b1;
        in_l = 16'sh7777;
        in_r = 16'sh7777;
        in_valid = 1'b1;
        @(negedge clk);
        chk("t6_no_strobe", out_valid, 0);
        chk("t6_out_l", out_l, 0);
        chk("t6_out_r", out_r, 0);
        chk("t6_in_en", in_en, 1);
        in_valid = 1'b0;
        reset = 1'b0;
        wait_strobe();
        chk("t6_first_cyc", cyc, 13);
        chk("t6_first_l", out_l, 0);
        wait_strobe();
        chk("t6_fifo_cleared", underrun, 1);
        chk("t6_second_l", out_l, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
